// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers decoded ops, snoops the ALU/LSB
// result buses to wake operands, and issues the lowest-index ready entry as a registered request.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_rob,
  input  logic              issue_qj_busy,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_rob,
  input  logic [DATA_W-1:0] alu_cdb_val,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_rob,
  input  logic [DATA_W-1:0] lsb_cdb_val,
  output logic              rs_full,
  output logic              alu_status,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [TAG_W-1:0]  alu_rob
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    logic              qj_busy;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic              qk_busy;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic              status_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] rs1_q;
  logic [DATA_W-1:0] rs2_q;
  logic [TAG_W-1:0]  rob_q;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;

  // Returns {still_pending, value} for one operand; the ALU bus wins a tie on the same tag.
  function automatic logic [DATA_W:0] snoop(input logic              pend,
                                            input logic [TAG_W-1:0]  tag,
                                            input logic [DATA_W-1:0] val);
    if (pend && alu_cdb_valid && alu_cdb_rob == tag) return {1'b0, alu_cdb_val};
    if (pend && lsb_cdb_valid && lsb_cdb_rob == tag) return {1'b0, lsb_cdb_val};
    return {pend, val};
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    ent_d      = ent_q;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!free_found && !ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_q[i].busy) begin
        {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
        {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
      end
    end

    // Free slot and selected slot come from registered state, so they never coincide.
    if (sel_found) ent_d[sel_idx].busy = 1'b0;

    if (issue_valid && free_found) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = issue_op;
      ent_d[free_idx].rob  = issue_rob;
      ent_d[free_idx].qj   = issue_qj;
      ent_d[free_idx].qk   = issue_qk;
      {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = snoop(issue_qj_busy, issue_qj, issue_vj);
      {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = snoop(issue_qk_busy, issue_qk, issue_vk);
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every register reading start-of-cycle values.
    if (rst_in || clear) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      status_q <= 1'b0;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rob_q    <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      status_q <= sel_found;
      if (sel_found) begin
        op_q  <= ent_q[sel_idx].op;
        rs1_q <= ent_q[sel_idx].vj;
        rs2_q <= ent_q[sel_idx].vk;
        rob_q <= ent_q[sel_idx].rob;
      end
    end
  end

  assign rs_full    = ~free_found;
  assign alu_status = status_q;
  assign alu_op     = op_q;
  assign alu_rs1    = rs1_q;
  assign alu_rs2    = rs2_q;
  assign alu_rob    = rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios followed by randomized traffic, all checked
// every cycle against a slot-array reference model of the reservation station.
module tb_alu_rs;
  localparam int DEPTH  = 8;
  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in, rdy_in, clear, issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_rob, issue_qj, issue_qk;
  logic              issue_qj_busy, issue_qk_busy;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic              alu_cdb_valid, lsb_cdb_valid;
  logic [TAG_W-1:0]  alu_cdb_rob, lsb_cdb_rob;
  logic [DATA_W-1:0] alu_cdb_val, lsb_cdb_val;
  logic              rs_full, alu_status;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_rs1, alu_rs2;
  logic [TAG_W-1:0]  alu_rob;

  alu_rs #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob(issue_rob),
    .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
    .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .rs_full(rs_full), .alu_status(alu_status), .alu_op(alu_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob(alu_rob)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a slot array holding waiting ops, plus the last request sent to the ALU.
  typedef struct {
    bit              busy;
    bit [OP_W-1:0]   op;
    bit [TAG_W-1:0]  rob;
    bit              jp;
    bit [TAG_W-1:0]  jt;
    bit [DATA_W-1:0] jv;
    bit              kp;
    bit [TAG_W-1:0]  kt;
    bit [DATA_W-1:0] kv;
  } slot_t;

  slot_t           m [DEPTH];
  bit              m_status;
  bit [OP_W-1:0]   m_op;
  bit [DATA_W-1:0] m_rs1, m_rs2;
  bit [TAG_W-1:0]  m_rob;

  function automatic bit [DATA_W:0] resolve(bit pend, bit [TAG_W-1:0] tag, bit [DATA_W-1:0] val);
    if (!pend) return {1'b0, val};
    if (alu_cdb_valid && alu_cdb_rob == tag) return {1'b0, alu_cdb_val};
    if (lsb_cdb_valid && lsb_cdb_rob == tag) return {1'b0, lsb_cdb_val};
    return {1'b1, val};
  endfunction

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int sel = -1;
    int fre = -1;
    bit full;
    if (rst_in || clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_status = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rob = '0;
      return;
    end
    if (!rdy_in) return;
    full = model_full();
    foreach (m[i]) begin
      if (!m[i].busy && fre < 0) fre = i;
      if (m[i].busy && !m[i].jp && !m[i].kp && sel < 0) sel = i;
    end
    foreach (m[i]) if (m[i].busy) begin
      {m[i].jp, m[i].jv} = resolve(m[i].jp, m[i].jt, m[i].jv);
      {m[i].kp, m[i].kv} = resolve(m[i].kp, m[i].kt, m[i].kv);
    end
    m_status = (sel >= 0);
    if (sel >= 0) begin
      m_op = m[sel].op; m_rs1 = m[sel].jv; m_rs2 = m[sel].kv; m_rob = m[sel].rob;
      m[sel].busy = 1'b0;
    end
    if (issue_valid && !full) begin
      m[fre].busy = 1'b1; m[fre].op = issue_op; m[fre].rob = issue_rob;
      m[fre].jt = issue_qj; m[fre].kt = issue_qk;
      {m[fre].jp, m[fre].jv} = resolve(issue_qj_busy, issue_qj, issue_vj);
      {m[fre].kp, m[fre].kv} = resolve(issue_qk_busy, issue_qk, issue_vk);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk_in);
    #1;
    check("alu_status", 64'(alu_status), 64'(m_status));
    check("rs_full", 64'(rs_full), 64'(model_full()));
    check("alu_op", 64'(alu_op), 64'(m_op));
    check("alu_rs1", 64'(alu_rs1), 64'(m_rs1));
    check("alu_rs2", 64'(alu_rs2), 64'(m_rs2));
    check("alu_rob", 64'(alu_rob), 64'(m_rob));
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear = 0; issue_valid = 0; issue_op = '0; issue_rob = '0;
    issue_qj_busy = 0; issue_qj = '0; issue_vj = '0; issue_qk_busy = 0; issue_qk = '0; issue_vk = '0;
    alu_cdb_valid = 0; alu_cdb_rob = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 0; lsb_cdb_rob = '0; lsb_cdb_val = '0;
  endtask

  task automatic issue(input int rob, input bit jb, input int jt, input int jv, input int kv);
    issue_valid = 1; issue_op = OP_W'(rob + 1); issue_rob = TAG_W'(rob);
    issue_qj_busy = jb; issue_qj = TAG_W'(jt); issue_vj = DATA_W'(jv);
    issue_qk_busy = 0; issue_qk = '0; issue_vk = DATA_W'(kv);
  endtask

  initial begin
    idle();
    // Reset held for two cycles
    rst_in = 1; step(); step();
    rst_in = 0;
    check("t1_status", 64'(alu_status), 64'd0);
    check("t1_full", 64'(rs_full), 64'd0);
    check("t1_rs1", 64'(alu_rs1), 64'd0);

    // Ready operands: dispatch on the very next edge, one-cycle pulse
    issue(3, 0, 0, 5, 7); step();
    idle(); step();
    check("t2_status", 64'(alu_status), 64'd1);
    check("t2_rs1", 64'(alu_rs1), 64'd5);
    check("t2_rs2", 64'(alu_rs2), 64'd7);
    check("t2_rob", 64'(alu_rob), 64'd3);
    step();
    check("t2_pulse", 64'(alu_status), 64'd0);

    // Wakeup from ALU bus, dispatch one cycle after the wake edge
    issue(4, 1, 9, 0, 2); step();
    idle(); step();
    alu_cdb_valid = 1; alu_cdb_rob = 5'd9; alu_cdb_val = 32'h10; step();
    check("t3_wake_edge", 64'(alu_status), 64'd0);
    idle(); step();
    check("t3_status", 64'(alu_status), 64'd1);
    check("t3_rs1", 64'(alu_rs1), 64'h10);

    // Same-cycle bypass from LSB bus
    issue(6, 1, 4, 0, 1);
    lsb_cdb_valid = 1; lsb_cdb_rob = 5'd4; lsb_cdb_val = 32'hAA; step();
    idle(); step();
    check("t4_status", 64'(alu_status), 64'd1);
    check("t4_rs1", 64'(alu_rs1), 64'hAA);

    // Fill all slots, drop the overflow, then drain in index order
    for (int i = 0; i < DEPTH; i++) begin issue(i, 1, 1, 0, i); step(); end
    check("t5_full", 64'(rs_full), 64'd1);
    issue(20, 1, 1, 0, 0); step();
    idle(); alu_cdb_valid = 1; alu_cdb_rob = 5'd1; alu_cdb_val = 32'h55; step();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check("t5_drain_status", 64'(alu_status), 64'd1);
      check("t5_drain_rob", 64'(alu_rob), 64'(i));
    end
    step();
    check("t5_overflow_dropped", 64'(alu_status), 64'd0);

    // Flush with three ready entries pending
    for (int i = 0; i < 3; i++) begin issue(10 + i, 1, 2, 0, i); step(); end
    idle(); alu_cdb_valid = 1; alu_cdb_rob = 5'd2; alu_cdb_val = 32'h77; step();
    idle(); clear = 1; step();
    check("t6_clear_status", 64'(alu_status), 64'd0);
    clear = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_stale", 64'(alu_status), 64'd0);
      check("t6_full", 64'(rs_full), 64'd0);
    end

    // Randomized traffic with a small tag space so wakeups and bypasses are frequent
    for (int c = 0; c < 3000; c++) begin
      rst_in        = ($urandom_range(0, 299) == 0);
      clear         = ($urandom_range(0, 79) == 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_op      = OP_W'($urandom);
      issue_rob     = TAG_W'($urandom);
      issue_qj_busy = $urandom_range(0, 1) == 1;
      issue_qj      = TAG_W'($urandom_range(0, 7));
      issue_vj      = $urandom;
      issue_qk_busy = $urandom_range(0, 1) == 1;
      issue_qk      = TAG_W'($urandom_range(0, 7));
      issue_vk      = $urandom;
      alu_cdb_valid = ($urandom_range(0, 2) == 0);
      alu_cdb_rob   = TAG_W'($urandom_range(0, 7));
      alu_cdb_val   = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 2) == 0);
      lsb_cdb_rob   = TAG_W'($urandom_range(0, 7));
      lsb_cdb_val   = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
